lcd_timing_gen: RTL and testbench



---
 rtl/lcd_timing_pkg.sv | 47 ++++
 rtl/lcd_pos_counter.sv | 57 +++++
 rtl/lcd_timing_gen.sv | 94 +++++++++
 tb/tb_lcd_timing_gen.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared timing constants and control-bundle type for the 800x480 LCD pipeline.
// The colour stage and the bench import this package too.
package lcd_timing_pkg;

    localparam int unsigned H_SYNC   = 1;
    localparam int unsigned H_BP     = 215;
    localparam int unsigned H_ACTIVE = 800;
    localparam int unsigned H_FP     = 40;
    localparam int unsigned V_SYNC   = 1;
    localparam int unsigned V_BP     = 34;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    // Active window bounds; END is exclusive.
    localparam int unsigned H_ACT_START = H_SYNC + H_BP;
    localparam int unsigned H_ACT_END   = H_ACT_START + H_ACTIVE;
    localparam int unsigned V_ACT_START = V_SYNC + V_BP;
    localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE;

    localparam int unsigned H_W   = 11;
    localparam int unsigned V_W   = 10;
    localparam int unsigned COL_W = 10;
    localparam int unsigned ROW_W = 9;

    typedef struct packed {
        logic             hd;
        logic             vd;
        logic             den;
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
        logic             frame_start;
    } lcd_ctrl_t;

    // Decode of the last pixel of a frame, which is where reset parks the counters.
    localparam lcd_ctrl_t LCD_CTRL_RST = '{
        hd:          1'b1,
        vd:          1'b1,
        den:         1'b0,
        col:         '0,
        row:         '0,
        frame_start: 1'b0
    };

endpackage

// File: rtl/lcd_pos_counter.sv
// Horizontal/vertical position counter pair, advanced once per pixel tick.
// Exposes the next-state position so the caller can register its decode on the same edge.
module lcd_pos_counter
    import lcd_timing_pkg::*;
#(
    parameter int unsigned P_H_TOTAL = H_TOTAL,
    parameter int unsigned P_V_TOTAL = V_TOTAL
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en_i,
    output logic [H_W-1:0] h_nxt_o,
    output logic [V_W-1:0] v_nxt_o,
    output logic           frame_wrap_o
);

    localparam logic [H_W-1:0] H_LAST = H_W'(P_H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST = V_W'(P_V_TOTAL - 1);

    logic [H_W-1:0] h_q, h_d;
    logic [V_W-1:0] v_q, v_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        h_d          = h_q;
        v_d          = v_q;
        frame_wrap_o = 1'b0;
        if (en_i) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d          = '0;
                    frame_wrap_o = 1'b1;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
        if (!rst_n) begin
            h_q <= H_LAST;
            v_q <= V_LAST;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_nxt_o = h_d;
    assign v_nxt_o = v_d;

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD timing generator: NCLK = CLK/2, panel syncs, data enable and active-area coordinates.
// Positions advance when NCLK falls, so every output is stable at the NCLK rising edge.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int unsigned P_H_SYNC   = H_SYNC,
    parameter int unsigned P_H_BP     = H_BP,
    parameter int unsigned P_H_ACTIVE = H_ACTIVE,
    parameter int unsigned P_H_FP     = H_FP,
    parameter int unsigned P_V_SYNC   = V_SYNC,
    parameter int unsigned P_V_BP     = V_BP,
    parameter int unsigned P_V_ACTIVE = V_ACTIVE,
    parameter int unsigned P_V_FP     = V_FP
) (
    input  logic             CLK,
    input  logic             RST_n,
    output logic             NCLK,
    output logic             GREST,
    output logic             HD,
    output logic             VD,
    output logic             DEN,
    output logic [COL_W-1:0] COL,
    output logic [ROW_W-1:0] ROW,
    output logic             FRAME_START
);

    localparam int unsigned P_H_TOTAL = P_H_SYNC + P_H_BP + P_H_ACTIVE + P_H_FP;
    localparam int unsigned P_V_TOTAL = P_V_SYNC + P_V_BP + P_V_ACTIVE + P_V_FP;

    localparam logic [H_W-1:0] H_SYNC_END = H_W'(P_H_SYNC);
    localparam logic [H_W-1:0] H_ACT_S    = H_W'(P_H_SYNC + P_H_BP);
    localparam logic [H_W-1:0] H_ACT_E    = H_W'(P_H_SYNC + P_H_BP + P_H_ACTIVE);
    localparam logic [V_W-1:0] V_SYNC_END = V_W'(P_V_SYNC);
    localparam logic [V_W-1:0] V_ACT_S    = V_W'(P_V_SYNC + P_V_BP);
    localparam logic [V_W-1:0] V_ACT_E    = V_W'(P_V_SYNC + P_V_BP + P_V_ACTIVE);

    logic           nclk_q;
    logic           grest_q;
    logic [H_W-1:0] h_nxt;
    logic [V_W-1:0] v_nxt;
    logic           frame_wrap;
    logic           hact;
    logic           vact;
    lcd_ctrl_t      ctrl_q, ctrl_d;

    lcd_pos_counter #(
        .P_H_TOTAL (P_H_TOTAL),
        .P_V_TOTAL (P_V_TOTAL)
    ) u_pos (
        .clk          (CLK),
        .rst_n        (RST_n),
        .en_i         (nclk_q),
        .h_nxt_o      (h_nxt),
        .v_nxt_o      (v_nxt),
        .frame_wrap_o (frame_wrap)
    );

    // Decode the position the counters move to, so outputs and h/v change on the same edge.
    always_comb begin
        hact   = (h_nxt >= H_ACT_S) && (h_nxt < H_ACT_E);
        vact   = (v_nxt >= V_ACT_S) && (v_nxt < V_ACT_E);
        ctrl_d = ctrl_q;
        if (nclk_q) begin
            ctrl_d.hd          = (h_nxt >= H_SYNC_END);
            ctrl_d.vd          = (v_nxt >= V_SYNC_END);
            ctrl_d.den         = hact && vact;
            ctrl_d.col         = (hact && vact) ? COL_W'(h_nxt - H_ACT_S) : '0;
            ctrl_d.row         = vact ? ROW_W'(v_nxt - V_ACT_S) : '0;
            ctrl_d.frame_start = frame_wrap;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            nclk_q  <= 1'b0;
            grest_q <= 1'b0;
            ctrl_q  <= LCD_CTRL_RST;
        end else begin
            nclk_q  <= ~nclk_q;
            grest_q <= 1'b1;
            ctrl_q  <= ctrl_d;
        end
    end

    assign NCLK        = nclk_q;
    assign GREST       = grest_q;
    assign HD          = ctrl_q.hd;
    assign VD          = ctrl_q.vd;
    assign DEN         = ctrl_q.den;
    assign COL         = ctrl_q.col;
    assign ROW         = ctrl_q.row;
    assign FRAME_START = ctrl_q.frame_start;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench: full-size instance for line/sync timing, a shrunken instance for whole-frame checks.
module tb_lcd_timing_gen;
    import lcd_timing_pkg::*;

    // Small geometry: line = 2+3+6+2 = 13 pixels, frame = 1+2+4+2 = 9 lines.
    localparam int S_HS = 2, S_HBP = 3, S_HACT = 6, S_HFP = 2;
    localparam int S_VS = 1, S_VBP = 2, S_VACT = 4, S_VFP = 2;
    localparam int S_HT        = S_HS + S_HBP + S_HACT + S_HFP;
    localparam int S_VT        = S_VS + S_VBP + S_VACT + S_VFP;
    localparam int S_LINE_CLK  = 2 * S_HT;
    localparam int S_FRAME_CLK = 2 * S_HT * S_VT;

    logic CLK   = 1'b0;
    logic RST_n = 1'b0;

    logic nclk, grest, hd, vd, den, fs;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic s_nclk, s_grest, s_hd, s_vd, s_den, s_fs;
    logic [COL_W-1:0] s_col;
    logic [ROW_W-1:0] s_row;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_pix0  = 0;

    lcd_timing_gen dut (
        .CLK (CLK), .RST_n (RST_n), .NCLK (nclk), .GREST (grest), .HD (hd), .VD (vd),
        .DEN (den), .COL (col), .ROW (row), .FRAME_START (fs)
    );

    lcd_timing_gen #(
        .P_H_SYNC (S_HS), .P_H_BP (S_HBP), .P_H_ACTIVE (S_HACT), .P_H_FP (S_HFP),
        .P_V_SYNC (S_VS), .P_V_BP (S_VBP), .P_V_ACTIVE (S_VACT), .P_V_FP (S_VFP)
    ) dut_s (
        .CLK (CLK), .RST_n (RST_n), .NCLK (s_nclk), .GREST (s_grest), .HD (s_hd), .VD (s_vd),
        .DEN (s_den), .COL (s_col), .ROW (s_row), .FRAME_START (s_fs)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    function automatic logic sig(input int sel);
        case (sel)
            0:       return hd;
            1:       return vd;
            2:       return s_hd;
            3:       return s_vd;
            default: return s_den;
        endcase
    endfunction

    // Sample on falling CLK edges until the selected signal reaches val; expiry counts as a failure.
    task automatic wait_sig(input int sel, input logic val, input int budget, output int t);
        bit ok = 1'b0;
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (sig(sel) === val) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL wait_sig%0d: got no level %b, required within %0d CLK", sel, val, budget);
        end
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        repeat (20) @(negedge CLK);
        n_tests++;
        if ({nclk, grest, hd, vd, den, fs} !== 6'b001100) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, expected 001100", {nclk, grest, hd, vd, den, fs});
        end
        n_tests++;
        if (col !== '0 || row !== '0) begin
            n_fail++;
            $display("FAIL reset_colrow: got col=%0d row=%0d, expected 0 0", col, row);
        end
        n_tests++;
        if ({s_nclk, s_grest, s_hd, s_vd, s_den, s_fs} !== 6'b001100 || s_col !== '0 || s_row !== '0) begin
            n_fail++;
            $display("FAIL reset_small: got %b col=%0d row=%0d, expected 001100 0 0",
                     {s_nclk, s_grest, s_hd, s_vd, s_den, s_fs}, s_col, s_row);
        end
    endtask

    task automatic test_release();
        RST_n = 1'b1;
        @(negedge CLK);
        n_tests++;
        if ({grest, nclk, hd, vd, fs} !== 5'b11110) begin
            n_fail++;
            $display("FAIL release_edge1: got grest,nclk,hd,vd,fs=%b, expected 11110", {grest, nclk, hd, vd, fs});
        end
        @(negedge CLK);
        t_pix0 = cyc;
        n_tests++;
        if ({nclk, hd, vd, fs, den} !== 5'b00010) begin
            n_fail++;
            $display("FAIL first_pixel: got nclk,hd,vd,fs,den=%b, expected 00010", {nclk, hd, vd, fs, den});
        end
        n_tests++;
        if ({s_nclk, s_hd, s_vd, s_fs, s_den} !== 5'b00010) begin
            n_fail++;
            $display("FAIL first_pixel_small: got %b, expected 00010", {s_nclk, s_hd, s_vd, s_fs, s_den});
        end
        @(negedge CLK);
        n_tests++;
        if (nclk !== 1'b1 || grest !== 1'b1) begin
            n_fail++;
            $display("FAIL nclk_toggle: got nclk=%b grest=%b, expected 1 1", nclk, grest);
        end
    endtask

    task automatic test_line_timing();
        int t, t1;
        wait_sig(0, 1'b1, 10, t);
        n_tests++;
        if (t - t_pix0 !== 2) begin
            n_fail++;
            $display("FAIL hd_low_width: got %0d CLK, expected 2", t - t_pix0);
        end
        wait_sig(1, 1'b1, 2200, t);
        t1 = t;
        n_tests++;
        if (t - t_pix0 !== 2112) begin
            n_fail++;
            $display("FAIL vd_low_width: got %0d CLK, expected 2112", t - t_pix0);
        end
        n_tests++;
        if (hd !== 1'b0 || fs !== 1'b0) begin
            n_fail++;
            $display("FAIL line1_start: got hd=%b fs=%b, expected 0 0", hd, fs);
        end
        wait_sig(0, 1'b1, 10, t);
        wait_sig(0, 1'b0, 2200, t);
        n_tests++;
        if (t - t1 !== 2112) begin
            n_fail++;
            $display("FAIL hd_period: got %0d CLK, expected 2112", t - t1);
        end
    endtask

    task automatic test_small_sync();
        int t, ta;
        wait_sig(3, 1'b1, 300, t);
        wait_sig(3, 1'b0, 300, ta);
        n_tests++;
        if ({s_hd, s_fs, s_den} !== 3'b010) begin
            n_fail++;
            $display("FAIL fs_coincident: got hd,fs,den=%b, expected 010", {s_hd, s_fs, s_den});
        end
        wait_sig(2, 1'b1, 20, t);
        n_tests++;
        if (t - ta !== 2 * S_HS) begin
            n_fail++;
            $display("FAIL s_hd_low_width: got %0d CLK, expected %0d", t - ta, 2 * S_HS);
        end
        wait_sig(3, 1'b1, S_FRAME_CLK, t);
        n_tests++;
        if (t - ta !== S_LINE_CLK * S_VS) begin
            n_fail++;
            $display("FAIL s_vd_low_width: got %0d CLK, expected %0d", t - ta, S_LINE_CLK * S_VS);
        end
    endtask

    task automatic test_active_window();
        int t;
        int den_pix = 0, col_err = 0, stab_err = 0, run_err = 0, run_clk = 0, fs_rises = 0;
        int first_off = -1, last_off = -1, vd_fall_off = -1;
        logic [COL_W-1:0] first_col = '1, last_col = '1, p_col;
        logic [ROW_W-1:0] first_row = '1, last_row = '1, p_row;
        logic p_den;
        logic [22:0] cur_s, cur_f, prev_s, prev_f;
        wait_sig(3, 1'b1, 300, t);
        wait_sig(3, 1'b0, 300, t);
        prev_s = {s_hd, s_vd, s_den, s_col, s_row, s_fs};
        prev_f = {hd, vd, den, col, row, fs};
        p_den = s_den; p_col = s_col; p_row = s_row;
        for (int off = 1; off <= 2 * S_FRAME_CLK; off++) begin
            @(negedge CLK);
            cur_s = {s_hd, s_vd, s_den, s_col, s_row, s_fs};
            cur_f = {hd, vd, den, col, row, fs};
            if (s_nclk === 1'b1) begin
                if (cur_s !== prev_s) stab_err++;
                if (cur_f !== prev_f) stab_err++;
                if (s_den === 1'b1) den_pix++;
            end else begin
                if (s_den === 1'b1) begin
                    if (!p_den && first_off < 0) begin
                        first_off = off; first_col = s_col; first_row = s_row;
                    end
                    if (p_den && (s_col !== p_col + 1'b1 || s_row !== p_row)) col_err++;
                    if (!p_den && s_col !== '0) col_err++;
                end else if (p_den && off <= S_FRAME_CLK) begin
                    last_off = off; last_col = p_col; last_row = p_row;
                end
                p_den = s_den; p_col = s_col; p_row = s_row;
            end
            if (s_den === 1'b1) begin
                run_clk++;
            end else begin
                if (run_clk != 0 && run_clk != 2 * S_HACT) run_err++;
                run_clk = 0;
            end
            if (s_fs === 1'b1 && prev_s[0] === 1'b0) fs_rises++;
            if (s_vd === 1'b0 && prev_s[21] === 1'b1 && vd_fall_off < 0) vd_fall_off = off;
            prev_s = cur_s;
            prev_f = cur_f;
        end
        n_tests++;
        if (first_off !== 2 * (3 * S_HT + 5) || first_col !== '0 || first_row !== '0) begin
            n_fail++;
            $display("FAIL first_den: got off=%0d col=%0d row=%0d, expected off=%0d col=0 row=0",
                     first_off, first_col, first_row, 2 * (3 * S_HT + 5));
        end
        n_tests++;
        if (last_off !== 2 * (6 * S_HT + 11) || last_col !== 10'(S_HACT - 1) || last_row !== 9'(S_VACT - 1)) begin
            n_fail++;
            $display("FAIL last_den: got off=%0d col=%0d row=%0d, expected off=%0d col=%0d row=%0d",
                     last_off, last_col, last_row, 2 * (6 * S_HT + 11), S_HACT - 1, S_VACT - 1);
        end
        n_tests++;
        if (den_pix !== 2 * S_HACT * S_VACT) begin
            n_fail++;
            $display("FAIL den_pixels: got %0d, expected %0d", den_pix, 2 * S_HACT * S_VACT);
        end
        n_tests++;
        if (col_err !== 0 || run_err !== 0) begin
            n_fail++;
            $display("FAIL col_step: got col_err=%0d run_err=%0d, expected 0 0", col_err, run_err);
        end
        n_tests++;
        if (stab_err !== 0) begin
            n_fail++;
            $display("FAIL nclk_rise_stable: got %0d changes, expected 0", stab_err);
        end
        n_tests++;
        if (fs_rises !== 2 || vd_fall_off !== S_FRAME_CLK) begin
            n_fail++;
            $display("FAIL frame_period: got fs_rises=%0d vd_fall=%0d, expected 2 %0d",
                     fs_rises, vd_fall_off, S_FRAME_CLK);
        end
    endtask

    task automatic test_mid_reset();
        int t, tr;
        bit found = 1'b0;
        for (int i = 0; i < 2 * S_FRAME_CLK; i++) begin
            @(negedge CLK);
            if (s_den === 1'b1 && s_row === 9'd2 && s_col === 10'd3) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL mid_target: got no pixel (3,2), required within %0d CLK", 2 * S_FRAME_CLK);
        end
        @(negedge CLK);
        #2 RST_n = 1'b0;
        #1;
        n_tests++;
        if ({s_nclk, s_grest, s_hd, s_vd, s_den, s_fs} !== 6'b001100 || s_col !== '0 || s_row !== '0) begin
            n_fail++;
            $display("FAIL async_reset_small: got %b col=%0d row=%0d, expected 001100 0 0",
                     {s_nclk, s_grest, s_hd, s_vd, s_den, s_fs}, s_col, s_row);
        end
        n_tests++;
        if ({nclk, grest, hd, vd, den, fs} !== 6'b001100) begin
            n_fail++;
            $display("FAIL async_reset_full: got %b, expected 001100", {nclk, grest, hd, vd, den, fs});
        end
        repeat (3) @(negedge CLK);
        RST_n = 1'b1;
        tr = cyc;
        wait_sig(3, 1'b0, 10, t);
        n_tests++;
        if (t - tr !== 2 || {s_fs, s_hd, s_den, s_grest} !== 4'b1001 || s_col !== '0 || s_row !== '0) begin
            n_fail++;
            $display("FAIL restart_origin: got dt=%0d fs,hd,den,grest=%b col=%0d row=%0d, expected dt=2 1001 0 0",
                     t - tr, {s_fs, s_hd, s_den, s_grest}, s_col, s_row);
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_line_timing();
        test_small_sync();
        test_active_window();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
